// File: rtl/gaplus_pkg.sv
// ============================================================================
// Module   : gaplus_pkg
// Purpose  : Shared starfield-control constants and channel-word helper.
// Revision : 1.0
// ============================================================================
`default_nettype none

package gaplus_pkg;

  localparam logic [1:0] STARCTL_CH1 = 2'd0;
  localparam logic [1:0] STARCTL_CH2 = 2'd1;
  localparam logic [1:0] STARCTL_CH3 = 2'd2;
  localparam logic [1:0] STARCTL_CTL = 2'd3;

  localparam int CH_W          = 5;
  localparam int CH_COARSE_BIT = 4;
  localparam int CH_DIR_BIT    = 3;
  localparam int CH_SPEED_MSB  = 2;
  localparam int CH_SPEED_LSB  = 0;

  function automatic logic [CH_W-1:0] ch_word(input logic       coarse,
                                              input logic       dir,
                                              input logic [2:0] speed);
    logic [CH_W-1:0] w;
    w                            = '0;
    w[CH_COARSE_BIT]             = coarse;
    w[CH_DIR_BIT]                = dir;
    w[CH_SPEED_MSB:CH_SPEED_LSB] = speed;
    return w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/gaplus_edge.sv
// ============================================================================
// Module   : gaplus_edge
// Purpose  : Registered rise/fall detector, optionally armed only after low.
// Revision : 1.0
// ============================================================================
`default_nettype none

module gaplus_edge #(
  parameter bit ARM_ON_LOW = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_rise,
  output logic o_fall
);

  logic r_prev;
  logic w_armed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_prev <= 1'b0;
    else        r_prev <= i_d;
  end

  // A level already high when reset releases must drop before it may count.
  if (ARM_ON_LOW) begin : g_arm
    logic r_armed;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    r_armed <= 1'b0;
      else if (!i_d) r_armed <= 1'b1;
    end
    assign w_armed = r_armed;
  end else begin : g_noarm
    assign w_armed = 1'b1;
  end

  assign o_rise = i_d & ~r_prev & w_armed;
  assign o_fall = ~i_d & r_prev;

endmodule

`default_nettype wire

// File: rtl/gaplus_starctl.sv
// ============================================================================
// Module   : gaplus_starctl
// Purpose  : CPU-shadowed starfield channel/enable registers, committed on
//            each vertical-blank falling edge.
// Revision : 1.0
// ============================================================================
`default_nettype none

module gaplus_starctl
  import gaplus_pkg::*;
(
  input  logic            VCLK,
  input  logic            RESET_N,
  input  logic            CS,
  input  logic            WR,
  input  logic [1:0]      AD,
  input  logic [7:0]      DI,
  output logic [7:0]      DO,
  input  logic            VB,
  output logic [CH_W-1:0] C1,
  output logic [CH_W-1:0] C2,
  output logic [CH_W-1:0] C3,
  output logic            STAREN,
  output logic            COMMIT,
  output logic            PEND
);

  logic            w_cswr;
  logic            w_wr_evt;
  logic            w_commit;
  logic            w_unused_wr_fall;
  logic            w_unused_vb_rise;
  logic            w_unused_di;
  logic [CH_W-1:0] w_word;
  logic [3:0]      w_pend_nxt;
  logic [7:0]      w_do_nxt;

  logic [CH_W-1:0] r_s1;
  logic [CH_W-1:0] r_s2;
  logic [CH_W-1:0] r_s3;
  logic            r_ctl;
  logic [3:0]      r_pend;

  assign w_cswr      = CS & WR;
  assign w_unused_di = ^DI[7:CH_W];
  assign w_word      = ch_word(DI[CH_COARSE_BIT], DI[CH_DIR_BIT],
                               DI[CH_SPEED_MSB:CH_SPEED_LSB]);

  gaplus_edge #(.ARM_ON_LOW(1'b1)) u_wr_edge (
    .clk    (VCLK),
    .rst_n  (RESET_N),
    .i_d    (w_cswr),
    .o_rise (w_wr_evt),
    .o_fall (w_unused_wr_fall)
  );

  gaplus_edge #(.ARM_ON_LOW(1'b0)) u_vb_edge (
    .clk    (VCLK),
    .rst_n  (RESET_N),
    .i_d    (VB),
    .o_rise (w_unused_vb_rise),
    .o_fall (w_commit)
  );

  // A write coinciding with a commit keeps its pending bit for the next frame.
  always_comb begin
    w_pend_nxt = w_commit ? 4'b0000 : r_pend;
    if (w_wr_evt) w_pend_nxt[AD] = 1'b1;
  end

  always_comb begin
    w_do_nxt = 8'h00;
    case (AD)
      STARCTL_CH1: w_do_nxt = {3'b000, r_s1};
      STARCTL_CH2: w_do_nxt = {3'b000, r_s2};
      STARCTL_CH3: w_do_nxt = {3'b000, r_s3};
      STARCTL_CTL: w_do_nxt = {6'b000000, PEND, r_ctl};
      default:     w_do_nxt = 8'h00;
    endcase
  end

  always_ff @(posedge VCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_s1   <= '0;
      r_s2   <= '0;
      r_s3   <= '0;
      r_ctl  <= 1'b0;
      r_pend <= 4'b0000;
      PEND   <= 1'b0;
      DO     <= 8'h00;
    end else begin
      if (w_wr_evt) begin
        case (AD)
          STARCTL_CH1: r_s1  <= w_word;
          STARCTL_CH2: r_s2  <= w_word;
          STARCTL_CH3: r_s3  <= w_word;
          STARCTL_CTL: r_ctl <= DI[0];
          default:     r_ctl <= r_ctl;
        endcase
      end
      r_pend <= w_pend_nxt;
      PEND   <= |w_pend_nxt;
      DO     <= w_do_nxt;
    end
  end

  // Committed outputs sample the shadows as they stood before this edge.
  always_ff @(posedge VCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      C1     <= '0;
      C2     <= '0;
      C3     <= '0;
      STAREN <= 1'b0;
      COMMIT <= 1'b0;
    end else begin
      COMMIT <= w_commit;
      if (w_commit) begin
        C1     <= r_s1;
        C2     <= r_s2;
        C3     <= r_s3;
        STAREN <= r_ctl;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_gaplus_starctl.sv
// ============================================================================
// Module   : tb_gaplus_starctl
// Purpose  : Directed scoreboard bench for gaplus_starctl.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_gaplus_starctl;

  logic       VCLK = 1'b0;
  logic       RESET_N;
  logic       CS;
  logic       WR;
  logic [1:0] AD;
  logic [7:0] DI;
  logic [7:0] DO;
  logic       VB;
  logic [4:0] C1;
  logic [4:0] C2;
  logic [4:0] C3;
  logic       STAREN;
  logic       COMMIT;
  logic       PEND;

  typedef struct {
    logic [4:0] c1;
    logic [4:0] c2;
    logic [4:0] c3;
    logic       staren;
    logic       pend;
  } exp_t;

  exp_t       sb[$];
  int         n_cmp = 0;
  int         n_bad = 0;

  logic [4:0] m_s [3];
  logic       m_ctl;
  logic [3:0] m_pend;

  gaplus_starctl dut (
    .VCLK    (VCLK),
    .RESET_N (RESET_N),
    .CS      (CS),
    .WR      (WR),
    .AD      (AD),
    .DI      (DI),
    .DO      (DO),
    .VB      (VB),
    .C1      (C1),
    .C2      (C2),
    .C3      (C3),
    .STAREN  (STAREN),
    .COMMIT  (COMMIT),
    .PEND    (PEND)
  );

  always #5 VCLK = ~VCLK;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every COMMIT pulse must match the oldest expected commit.
  always @(negedge VCLK) begin
    if (RESET_N === 1'b1 && COMMIT === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL commit_unexpected: got COMMIT=1 expected no commit at %0t", $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("commit_c1",     8'(C1),     8'(e.c1));
        chk("commit_c2",     8'(C2),     8'(e.c2));
        chk("commit_c3",     8'(C3),     8'(e.c3));
        chk("commit_staren", 8'(STAREN), 8'(e.staren));
        chk("commit_pend",   8'(PEND),   8'(e.pend));
      end
    end
  end

  task automatic model_reset();
    for (int i = 0; i < 3; i++) m_s[i] = 5'd0;
    m_ctl  = 1'b0;
    m_pend = 4'b0000;
  endtask

  task automatic model_write(input logic [1:0] ad, input logic [7:0] d);
    if (ad == 2'd3) m_ctl = d[0];
    else            m_s[ad] = d[4:0];
    m_pend[ad] = 1'b1;
  endtask

  function automatic exp_t snap(input logic pend_after);
    exp_t e;
    e.c1     = m_s[0];
    e.c2     = m_s[1];
    e.c3     = m_s[2];
    e.staren = m_ctl;
    e.pend   = pend_after;
    return e;
  endfunction

  // Strobe held for 'hold' cycles; DI switches to d_late after the first cycle.
  task automatic do_write(input logic [1:0] ad, input logic [7:0] d,
                          input int hold, input logic [7:0] d_late);
    @(negedge VCLK);
    CS = 1'b1; WR = 1'b1; AD = ad; DI = d;
    @(negedge VCLK);
    DI = d_late;
    repeat (hold - 1) @(negedge VCLK);
    CS = 1'b0; WR = 1'b0;
    model_write(ad, d);
    @(negedge VCLK);
  endtask

  task automatic read_do(input string name, input logic [1:0] ad, input logic [7:0] exp);
    @(negedge VCLK);
    AD = ad;
    @(negedge VCLK);
    chk(name, DO, exp);
  endtask

  task automatic vb_frame();
    @(negedge VCLK);
    VB = 1'b1;
    repeat (3) @(negedge VCLK);
    sb.push_back(snap(1'b0));
    m_pend = 4'b0000;
    VB = 1'b0;
    repeat (2) @(negedge VCLK);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1);
  end

  initial begin
    RESET_N = 1'b0; CS = 1'b0; WR = 1'b0; AD = 2'd0; DI = 8'h00; VB = 1'b0;
    model_reset();
    repeat (3) @(negedge VCLK);
    chk("rst_c1",     8'(C1),     8'h00);
    chk("rst_c2",     8'(C2),     8'h00);
    chk("rst_c3",     8'(C3),     8'h00);
    chk("rst_staren", 8'(STAREN), 8'h00);
    chk("rst_commit", 8'(COMMIT), 8'h00);
    chk("rst_pend",   8'(PEND),   8'h00);
    chk("rst_do",     DO,         8'h00);
    RESET_N = 1'b1;
    repeat (3) @(negedge VCLK);

    // Idle frames: commits of all-zero state.
    vb_frame();
    vb_frame();
    chk("idle_pend", 8'(PEND), 8'h00);

    // Long strobe with DI changing mid-strobe: only the first value lands.
    do_write(2'd0, 8'h1B, 10, 8'h04);
    chk("wr1_pend",  8'(PEND), 8'h01);
    chk("wr1_c1_hold", 8'(C1), 8'h00);
    read_do("wr1_do", 2'd0, 8'h1B);
    vb_frame();
    chk("wr1_c1",   8'(C1),   8'h1B);
    chk("wr1_pend_clr", 8'(PEND), 8'h00);

    // Control register: readback shows pending then committed enable.
    do_write(2'd3, 8'hFF, 2, 8'hFF);
    read_do("ctl_do_pend", 2'd3, 8'h03);
    vb_frame();
    read_do("ctl_do_done", 2'd3, 8'h01);
    chk("ctl_staren", 8'(STAREN), 8'h01);

    // Write coincident with the VB fall: commit uses pre-write shadow.
    @(negedge VCLK);
    VB = 1'b1;
    repeat (3) @(negedge VCLK);
    sb.push_back(snap(1'b1));
    m_pend = 4'b0000;
    VB = 1'b0; CS = 1'b1; WR = 1'b1; AD = 2'd2; DI = 8'h05;
    @(negedge VCLK);
    CS = 1'b0; WR = 1'b0;
    model_write(2'd2, 8'h05);
    @(negedge VCLK);
    chk("same_c3_old", 8'(C3),   8'h00);
    chk("same_pend",   8'(PEND), 8'h01);
    read_do("same_do", 2'd2, 8'h05);
    vb_frame();
    chk("same_c3_new", 8'(C3),   8'h05);
    chk("same_pend_clr", 8'(PEND), 8'h00);

    // Last write wins.
    do_write(2'd1, 8'h12, 3, 8'h12);
    do_write(2'd1, 8'h0A, 3, 8'h0A);
    read_do("lww_do", 2'd1, 8'h0A);
    vb_frame();
    chk("lww_c2", 8'(C2), 8'h0A);

    // Reset mid-strobe and mid-frame, released with the strobe still high.
    @(negedge VCLK);
    CS = 1'b1; WR = 1'b1; AD = 2'd0; DI = 8'h11; VB = 1'b1;
    repeat (2) @(negedge VCLK);
    chk("pre_rst_pend", 8'(PEND), 8'h01);
    RESET_N = 1'b0;
    #1;
    chk("mid_rst_c1",     8'(C1),     8'h00);
    chk("mid_rst_staren", 8'(STAREN), 8'h00);
    chk("mid_rst_pend",   8'(PEND),   8'h00);
    chk("mid_rst_do",     DO,         8'h00);
    model_reset();
    @(negedge VCLK);
    VB = 1'b0;
    @(negedge VCLK);
    RESET_N = 1'b1;
    repeat (6) @(negedge VCLK);
    chk("rel_pend", 8'(PEND), 8'h00);
    chk("rel_do",   DO,       8'h00);
    chk("rel_c3",   8'(C3),   8'h00);
    CS = 1'b0; WR = 1'b0;
    @(negedge VCLK);

    // Fresh strobe after the drop is accepted; upper DI bits ignored.
    do_write(2'd1, 8'hE7, 2, 8'hE7);
    chk("post_pend", 8'(PEND), 8'h01);
    vb_frame();
    chk("post_c2", 8'(C2), 8'h07);

    repeat (3) @(negedge VCLK);
    chk("sb_drained", 8'(sb.size()), 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
